// File: rtl/qadd_rr_sched.sv
// Round-robin scheduler sharing one sign-magnitude fixed-point adder among NREQ requesters.
// One operand pair is accepted per transaction; the registered sum returns with its requester ID and an overflow flag.
module qadd_rr_sched #(
    parameter int N    = 16,
    parameter int Q    = 8,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_ovf,
    output logic              busy,
    output logic [1:0]        dbg_state_o
);

    generate
        if (Q >= N || NREQ < 2 || (1 << IDW) < NREQ) begin : g_param_check
            $error("qadd_rr_sched: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic [N-1:0]   op_a_q, op_a_d;
    logic [N-1:0]   op_b_q, op_b_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [N-1:0]   rsp_data_q, rsp_data_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_ovf_q, rsp_ovf_d;

    // Rotating search: offset k from the pointer, first valid requester wins.
    logic           grant_found;
    logic [IDW-1:0] grant_id;
    logic [IDW:0]   cand;

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!grant_found && req_valid[j] && cand == (IDW+1)'(j)) begin
                    grant_found = 1'b1;
                    grant_id    = IDW'(j);
                end
            end
        end
    end

    logic [N-1:0] sel_a, sel_b;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (grant_id == IDW'(j)) begin
                sel_a = req_a[j*N +: N];
                sel_b = req_b[j*N +: N];
            end
        end
    end

    // Shared sign-magnitude adder; opposite-sign zero results are forced positive.
    logic [N-2:0] mag_a, mag_b, diff_ab, diff_ba;
    logic [N-1:0] mag_sum;
    logic [N-1:0] sum;
    logic         sum_ovf;

    always_comb begin
        mag_a   = op_a_q[N-2:0];
        mag_b   = op_b_q[N-2:0];
        mag_sum = {1'b0, mag_a} + {1'b0, mag_b};
        diff_ab = mag_a - mag_b;
        diff_ba = mag_b - mag_a;
        sum_ovf = 1'b0;
        if (op_a_q[N-1] == op_b_q[N-1]) begin
            sum     = {op_a_q[N-1], mag_sum[N-2:0]};
            sum_ovf = mag_sum[N-1];
        end else if (mag_a >= mag_b) begin
            sum = {op_a_q[N-1] & (diff_ab != '0), diff_ab};
        end else begin
            sum = {op_b_q[N-1], diff_ba};
        end
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid, once raised, is held with its payload until that edge.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_ovf_d   = rsp_ovf_q;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready = NREQ'(1) << grant_id;
                    op_a_d    = sel_a;
                    op_b_d    = sel_b;
                    gid_d     = grant_id;
                    ptr_d     = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
                    state_d   = CALC;
                end
            end
            CALC: begin
                rsp_data_d  = sum;
                rsp_ovf_d   = sum_ovf;
                rsp_id_d    = gid_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!rst_n) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gid_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gid_q       <= gid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_ovf     = rsp_ovf_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule
